mult8_sequencer: RTL and testbench
==================================

# mult8_sequencer

Sequential 8x8 unsigned multiplier controller that sits directly around the combinational 4x4 nibble multiplier. It accepts 8-bit operand pairs over a valid/ready handshake and feeds the 4x4 multiplier four nibble pairs over four cycles. It consumes each 8-bit partial product, shift-accumulates it into a 16-bit result, and presents that result over a second valid/ready handshake. The 4x4 multiplier is instantiated beside this block at top level, so the block's only arithmetic is a 16-bit shifted add.

## Interface
- ZERO_SKIP, default 1: when 1, an operand pair with either operand equal to 0 bypasses the multiply steps.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  8  multiplicand, unsigned.
- in_b  input  8  multiplier, unsigned.
- mul_a  output  4  nibble to 4x4 multiplier inputs a3..a0 (bit 0 = a0).
- mul_b  output  4  nibble to 4x4 multiplier inputs b3..b0.
- mul_p  input  8  4x4 product, {c, p6..p0}, combinational from mul_a/mul_b.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes result.
- out_p  output  16  product in_a*in_b.

## Operation
- FSM states: IDLE, MUL, DONE.
- Registers: a_q[7:0], b_q[7:0], step[1:0], acc[15:0].
- IDLE:
  - in_ready=1.
  - On in_valid, capture a_q/b_q, clear acc, set step=0, go to MUL.
  - If ZERO_SKIP=1 and (in_a==0 or in_b==0), go directly to DONE with acc=0 instead.
- MUL: in_ready=0. Nibble pair per step, with the shift applied to mul_p:
  - step0: mul_a=a_q[3:0], mul_b=b_q[3:0], shift 0.
  - step1: mul_a=a_q[7:4], mul_b=b_q[3:0], shift 4.
  - step2: mul_a=a_q[3:0], mul_b=b_q[7:4], shift 4.
  - step3: mul_a=a_q[7:4], mul_b=b_q[7:4], shift 8.
- MUL accumulate: each edge sets acc <= acc + ({8'b0,mul_p} << shift) and step <= step+1. After step3, go to DONE.
- DONE:
  - out_valid=1, out_p=acc, held stable until out_ready=1.
  - On out_ready, go to IDLE.
- Arithmetic width:
  - All arithmetic is unsigned, 16-bit.
  - Maximum 255*255 = 0xFE01, so no overflow is possible.
  - Intermediate sums never exceed the final product.
- mul_a/mul_b are 0 in IDLE and DONE.
- out_p outputs acc in every state and is only meaningful while out_valid=1.
- in_valid is ignored outside IDLE. Operands are not re-sampled during MUL or DONE.
- rst asserted in any state, including mid-MUL or DONE with out_valid high:
  - Return immediately to IDLE; pending result discarded.
  - in_ready=1, out_valid=0, out_p=0, mul_a=0, mul_b=0, acc=0, step=0, a_q=0, b_q=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_p=16'h0000, mul_a=4'h0, mul_b=4'h0.
- Accept at edge E0 (in_valid & in_ready). Normal path timing:
  - MUL occupies the cycles after E0..E3.
  - Accumulation occurs on E1..E4.
  - out_valid rises after E4: latency 4 cycles.
- Zero-skip path: out_valid rises after E0, latency 1 cycle, and mul_a/mul_b stay 0 throughout.
- Result handoff: if out_ready is already high when out_valid rises, the result is consumed on the next edge (out_valid high for exactly 1 cycle).
- Throughput:
  - in_ready is not asserted in DONE, so the earliest next accept is one cycle after the handoff edge.
  - Back-to-back throughput is one result per 6 cycles with out_ready tied high.
- mul_p path: mul_p is sampled on the same edge that advances step. The 4x4 multiplier path is therefore a single-cycle combinational path from a_q/b_q/step.

## Test plan
- 0x96 * 0x69, out_ready=1 -> mul_a/mul_b sequence (6,9),(9,9),(6,6),(9,6); out_p=16'h3D86 after 4 cycles; out_valid high exactly 1 cycle.
- 0xFF * 0xFF, then 0xA5 * 0x5A back-to-back with in_valid held high -> out_p=16'hFE01, then 16'h3A02; second accept occurs one cycle after the first handoff; in_ready low from accept through handoff.
- 0x00 * 0x7F with ZERO_SKIP=1 -> out_valid after 1 cycle, out_p=0, mul_a/mul_b never leave 0. The same pair with ZERO_SKIP=0 -> 4-cycle path, out_p=0.
- 0x0F * 0xF0, out_ready low for 10 cycles after out_valid -> out_p=16'h0E10 held stable, in_ready=0 throughout, a new in_valid ignored; result consumed on the first out_ready edge.
- rst pulse during step2 of 0xC3 * 0x3C -> immediately out_valid=0, out_p=0, in_ready=1. Next pair 0x11 * 0x11 -> out_p=16'h0121, with no residue from the aborted operation.

Source files
------------

// File: rtl/mult8_sequencer.sv
// Sequential 8x8 unsigned multiplier controller driving an external 4x4 nibble multiplier.
// Four nibble products are shift-accumulated into a 16-bit result presented over valid/ready.
module mult8_sequencer #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_a, r_b;
  logic [1:0]  r_step;
  logic [15:0] r_acc;
  logic [3:0]  w_shift;
  logic [15:0] w_pp;
  logic        w_zero;

  assign w_zero = ZERO_SKIP && ((in_a == 8'd0) || (in_b == 8'd0));
  assign w_pp   = {8'd0, mul_p} << w_shift;
  assign out_p  = r_acc;

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_a      = 4'd0;
    mul_b      = 4'd0;
    w_shift    = 4'd0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = w_zero ? DONE : MUL;
      end
      MUL: begin
        // Cross terms (step1/step2) both carry weight 2^4.
        case (r_step)
          2'd0: begin mul_a = r_a[3:0]; mul_b = r_b[3:0]; w_shift = 4'd0; end
          2'd1: begin mul_a = r_a[7:4]; mul_b = r_b[3:0]; w_shift = 4'd4; end
          2'd2: begin mul_a = r_a[3:0]; mul_b = r_b[7:4]; w_shift = 4'd4; end
          default: begin mul_a = r_a[7:4]; mul_b = r_b[7:4]; w_shift = 4'd8; end
        endcase
        if (r_step == 2'd3) w_state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_step <= 2'd0;
      r_acc  <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_a    <= in_a;
          r_b    <= in_b;
          r_step <= 2'd0;
          r_acc  <= 16'd0;
        end
        MUL: begin
          r_acc  <= r_acc + w_pp;
          r_step <= r_step + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult8_sequencer.sv
// Randomized self-checking bench for mult8_sequencer; reference is plain a*b plus the nibble schedule.
module tb_mult8_sequencer;
  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_a, in_b, mul_p;
  logic [3:0]  mul_a, mul_b;
  logic [15:0] out_p;
  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [7:0]  mul_p0;
  logic [3:0]  mul_a0, mul_b0;
  logic [15:0] out_p0;
  int n_vec = 0, n_err = 0;

  mult8_sequencer #(.ZERO_SKIP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p));

  mult8_sequencer #(.ZERO_SKIP(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_p(out_p0));

  // Behavioural 4x4 nibble multipliers sitting beside each instance.
  assign mul_p  = 8'({4'd0, mul_a}  * {4'd0, mul_b});
  assign mul_p0 = 8'({4'd0, mul_a0} * {4'd0, mul_b0});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handoff edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [15:0] exp;
    logic [3:0]  na, nb;
    exp = 16'(a) * 16'(b);
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = (hold == 0);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    if (a != 8'd0 && b != 8'd0) begin
      for (int k = 0; k < 4; k++) begin
        na = k[0] ? a[7:4] : a[3:0];
        nb = k[1] ? b[7:4] : b[3:0];
        @(negedge clk);
        chk("mul_a", 32'(mul_a), 32'(na));
        chk("mul_b", 32'(mul_b), 32'(nb));
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        chk("early_valid", 32'(out_valid), 32'd0);
      end
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_p", 32'(out_p), 32'(exp));
    chk("done_mul_ab", 32'({mul_a, mul_b}), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    repeat (hold) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_out_p", 32'(out_p), 32'(exp));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("handoff_valid", 32'(out_valid), 32'd0);
    chk("handoff_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic run_op0(input logic [7:0] a, input logic [7:0] b);
    in_valid0 = 1'b1; in_a = a; in_b = b;
    chk("zs0_in_ready", 32'(in_ready0), 32'd1);
    @(posedge clk); #1 in_valid0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("zs0_early_valid", 32'(out_valid0), 32'd0);
    end
    @(negedge clk);
    chk("zs0_out_valid", 32'(out_valid0), 32'd1);
    chk("zs0_out_p", 32'(out_p0), 32'(16'(a) * 16'(b)));
    @(negedge clk);
    chk("zs0_handoff", 32'(out_valid0), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b0; out_ready0 = 1'b1;
    in_a = 8'd0; in_b = 8'd0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_p", 32'(out_p), 32'd0);
    chk("rst_mul_ab", 32'({mul_a, mul_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h96, 8'h69, 0);
    chk("directed_3D86", 32'(16'h96 * 16'h69), 32'h3D86);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'hA5, 8'h5A, 0);
    run_op(8'h00, 8'h7F, 0);
    run_op(8'h0F, 8'hF0, 10);

    // Reset in the middle of step2 of C3*3C.
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h3C; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("step2_mul_a", 32'(mul_a), 32'h3);
    chk("step2_mul_b", 32'(mul_b), 32'h3);
    rst = 1'b1; #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_p", 32'(out_p), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_mul_ab", 32'({mul_a, mul_b}), 32'd0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    run_op(8'h11, 8'h11, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)));
    end

    run_op0(8'h00, 8'h7F);
    for (int i = 0; i < 6; i++) run_op0(8'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
